// File: rtl/noc_pkg.sv
// Shared definitions for the NoC 1-to-2 demux scheduler.
// Contents: flit geometry, credit depth, flit type and FSM state encodings,
// and the demux select encodings.
package noc_pkg;

  localparam int FLIT_W     = 16;
  localparam int DEST_BIT   = 13;
  localparam int CREDIT_MAX = 4;
  localparam int CREDIT_W   = $clog2(CREDIT_MAX + 1);

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HEAD   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } sched_state_e;

  localparam logic [1:0] DEMUX_SEL_P0 = 2'b00;
  localparam logic [1:0] DEMUX_SEL_P1 = 2'b01;

endpackage

// File: rtl/noc_demux_sched_if.sv
// Bus bundle between the upstream flit source / downstream demux and the scheduler.
// slave  : scheduler view (consumes flits and credit returns, drives the demux).
// master : environment view (drives flits and credit returns, observes the demux).
//
// Handshake: a flit transfers on a rising clk edge where in_valid_i & in_ready_o.
// in_ready_o is a function of state, in_data_i and credits only, never of
// in_valid_i; the source holds in_data_i stable while in_valid_i is high and
// not yet accepted. demux_en_o / out_valid_o are single-cycle pushes with no
// back-pressure: downstream space is guaranteed by the credit counters.
//
// state_dbg and credit_dbg expose the FSM state and per-port credit counts.
interface noc_demux_sched_if;
  import noc_pkg::*;

  logic [FLIT_W-1:0]            in_data_i;
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [1:0]                   credit_ret_i;
  logic [FLIT_W-1:0]            demux_data_o;
  logic [1:0]                   demux_sel_o;
  logic                         demux_en_o;
  logic [1:0]                   out_valid_o;
  logic                         busy_o;
  logic                         err_o;
  sched_state_e                 state_dbg;
  logic [1:0][CREDIT_W-1:0]     credit_dbg;

  modport slave (
    input  in_data_i, in_valid_i, credit_ret_i,
    output in_ready_o, demux_data_o, demux_sel_o, demux_en_o, out_valid_o,
           busy_o, err_o, state_dbg, credit_dbg
  );

  modport master (
    output in_data_i, in_valid_i, credit_ret_i,
    input  in_ready_o, demux_data_o, demux_sel_o, demux_en_o, out_valid_o,
           busy_o, err_o, state_dbg, credit_dbg
  );

endinterface

// File: rtl/noc_credit_counter.sv
// Downstream credit counter for one output port.
// Ports: clk_i, rst_i (async, active-high), dec_i (flit forwarded),
// inc_i (credit returned), avail_o (current credit count),
// ovf_o (combinational: a return arrived while already full).
module noc_credit_counter #(
  parameter int CREDIT_MAX = 4,
  parameter int CREDIT_W   = $clog2(CREDIT_MAX + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                dec_i,
  input  logic                inc_i,
  output logic [CREDIT_W-1:0] avail_o,
  output logic                ovf_o
);

  localparam logic [CREDIT_W-1:0] MAX_V = CREDIT_W'(CREDIT_MAX);

  logic [CREDIT_W-1:0] count;

  // A simultaneous return and forward cancel out, so only a lone return at
  // full scale is an overflow.
  always_comb begin
    ovf_o = inc_i & ~dec_i & (count == MAX_V);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= MAX_V;
    end else if (inc_i && !dec_i) begin
      if (count != MAX_V) count <= count + 1'b1;
    end else if (dec_i && !inc_i) begin
      count <= count - 1'b1;  // never at 0: a forward requires a credit
    end
  end

  assign avail_o = count;

endmodule

// File: rtl/noc_demux_sched.sv
// Wormhole scheduler for the NoC 1-to-2 demux stage.
// Ports: clk_i, rst_i (async, active-high) and bus (noc_demux_sched_if.slave):
//   in_data_i/in_valid_i/in_ready_o  incoming flit handshake
//   credit_ret_i                     per-port credit return pulses
//   demux_data_o/demux_sel_o/demux_en_o/out_valid_o  registered demux drive
//   busy_o (packet locked), err_o (registered protocol-error pulse)
//   state_dbg, credit_dbg            FSM state and credit counts
// A head flit locks the path to its destination until the tail flit; flits
// of the wrong kind for the current state are accepted and dropped with err_o.
module noc_demux_sched
  import noc_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  noc_demux_sched_if.slave   bus
);

  sched_state_e               state, state_next;
  flit_type_e                 ftype;
  logic                       dest;
  logic                       ready, fwd, drop, port;
  logic [1:0]                 avail, dec, ovf;
  logic [1:0][CREDIT_W-1:0]   credits;

  logic [FLIT_W-1:0]          data_q;
  logic [1:0]                 sel_q, valid_q;
  logic                       en_q, err_q;

  assign ftype = flit_type_e'(bus.in_data_i[FLIT_W-1 -: 2]);
  assign dest  = bus.in_data_i[DEST_BIT];
  assign avail = {credits[1] != '0, credits[0] != '0};
  assign dec   = fwd ? (port ? 2'b10 : 2'b01) : 2'b00;

  noc_credit_counter #(.CREDIT_MAX(CREDIT_MAX), .CREDIT_W(CREDIT_W)) u_credit0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .dec_i   (dec[0]),
    .inc_i   (bus.credit_ret_i[0]),
    .avail_o (credits[0]),
    .ovf_o   (ovf[0])
  );

  noc_credit_counter #(.CREDIT_MAX(CREDIT_MAX), .CREDIT_W(CREDIT_W)) u_credit1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .dec_i   (dec[1]),
    .inc_i   (bus.credit_ret_i[1]),
    .avail_o (credits[1]),
    .ovf_o   (ovf[1])
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Ready/accept decode and next state. Misplaced flits are always accepted
  // so a broken upstream cannot wedge the input.
  always_comb begin
    ready      = 1'b0;
    fwd        = 1'b0;
    drop       = 1'b0;
    port       = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        port = dest;
        if (ftype == FT_HEAD || ftype == FT_SINGLE) begin
          ready = avail[dest];
          fwd   = bus.in_valid_i & ready;
          if (fwd && ftype == FT_HEAD) state_next = dest ? LOCK1 : LOCK0;
        end else begin
          ready = 1'b1;
          drop  = bus.in_valid_i;
        end
      end
      LOCK0, LOCK1: begin
        port = (state == LOCK1);
        if (ftype == FT_BODY || ftype == FT_TAIL) begin
          ready = avail[port];
          fwd   = bus.in_valid_i & ready;
          if (fwd && ftype == FT_TAIL) state_next = IDLE;
        end else begin
          ready = 1'b1;
          drop  = bus.in_valid_i;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output stage: data and select only update on a forwarded flit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      sel_q   <= DEMUX_SEL_P0;
      en_q    <= 1'b0;
      valid_q <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      en_q    <= fwd;
      valid_q <= dec;
      err_q   <= drop | ovf[0] | ovf[1];
      if (fwd) begin
        data_q <= bus.in_data_i;
        sel_q  <= port ? DEMUX_SEL_P1 : DEMUX_SEL_P0;
      end
    end
  end

  assign bus.in_ready_o   = ready;
  assign bus.demux_data_o = data_q;
  assign bus.demux_sel_o  = sel_q;
  assign bus.demux_en_o   = en_q;
  assign bus.out_valid_o  = valid_q;
  assign bus.busy_o       = (state != IDLE);
  assign bus.err_o        = err_q;
  assign bus.state_dbg    = state;
  assign bus.credit_dbg   = credits;

endmodule
